// File: rtl/reg_file_pkg.sv
// Shared definitions for the LC3 pipelined register file slice.
// Holds the default geometry (data width, address width, read port count)
// and a helper that derives the register count from the address width.
// Build option: REG_FILE_BYPASS_EN (see reg_file_sb) enables write-to-read
// forwarding; the default build has no forwarding path.
package reg_file_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;
  localparam int DEF_NRD    = 2;

  // Every address value is a real register, so the count is a full power of two.
  function automatic int nregs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy scoreboard for the LC3 pipeline.
// Decode reserves a destination register (rsv_*), writeback releases it (wr_*).
// Ports:
//   clk       system clock, all state on the rising edge
//   reset     synchronous active-low reset (0 = reset)
//   wr_en     writeback strobe, releases busy[wr_addr]
//   wr_addr   writeback register index
//   rsv_en    reserve request from decode, sets busy[rsv_addr]
//   rsv_addr  register to reserve
//   busy_vec  live scoreboard, bit i = register i busy
//   rsv_err   one-cycle pulse: a reserve hit a register that was still busy
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  localparam int NREGS = nregs(ADDR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic [NREGS-1:0]  busy_vec,
  output logic              rsv_err
);

  logic [NREGS-1:0] busy_next;
  logic             err_next;

  // Release is applied before reserve, so a same-cycle write and reserve on
  // one register leave it busy: the new reservation belongs to a younger
  // instruction and must survive the older one's writeback.
  // A reserve only counts as a collision if the register stays busy after
  // this cycle's writeback has been taken into account.
  always_comb begin
    busy_next = busy_vec;
    if (wr_en) busy_next[wr_addr] = 1'b0;
    if (rsv_en) busy_next[rsv_addr] = 1'b1;
    err_next = rsv_en && busy_vec[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      busy_vec <= '0;
      rsv_err  <= 1'b0;
    end else begin
      busy_vec <= busy_next;
      rsv_err  <= err_next;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-port register file with per-register scoreboard for the pipelined
// LC3 datapath: one write port, NRD registered read ports (1-cycle latency),
// each read also reporting the busy bit so issue logic can stall on RAW hazards.
// Ports:
//   clk       system clock, all state on the rising edge
//   reset     synchronous active-low reset (0 = reset)
//   wr_en     writeback strobe
//   wr_addr   writeback register index
//   wr_data   writeback data
//   rsv_en    reserve (mark busy) request from decode
//   rsv_addr  register to reserve
//   rsv_err   one-cycle pulse: reserve hit an already-busy register
//   rd_en     per-port read strobe (port p = bit p)
//   rd_addr   port p address at [p*ADDR_W +: ADDR_W]
//   rd_data   port p data at [p*DATA_W +: DATA_W], holds when rd_en[p]=0
//   rd_busy   port p busy bit captured with the read, holds when rd_en[p]=0
//   busy_vec  live scoreboard, bit i = register i busy
// Build option REG_FILE_BYPASS_EN: a read of the register being written in
// the same cycle returns wr_data and the post-write busy state. Without it
// the read returns the old register contents and old busy bit.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  localparam int NREGS = nregs(ADDR_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rsv_en,
  input  logic [ADDR_W-1:0]     rsv_addr,
  output logic                  rsv_err,
  input  logic [NRD-1:0]        rd_en,
  input  logic [NRD*ADDR_W-1:0] rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  output logic [NREGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] mem [NREGS];
  logic [DATA_W-1:0] rd_data_next [NRD];
  logic [NRD-1:0]    rd_busy_next;
  logic [ADDR_W-1:0] addr;

  reg_file_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .busy_vec(busy_vec),
    .rsv_err (rsv_err)
  );

  // Storage array; reset clears every register so the datapath starts from
  // a known architectural state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read muxes: value and busy bit as they stand before this edge's updates,
  // optionally overridden by the forwarding path when the write port targets
  // the same register.
  always_comb begin
    addr         = '0;
    rd_busy_next = '0;
    for (int p = 0; p < NRD; p++) begin
      addr            = rd_addr[p*ADDR_W +: ADDR_W];
      rd_data_next[p] = mem[addr];
      rd_busy_next[p] = busy_vec[addr];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en && (wr_addr == addr)) begin
        rd_data_next[p] = wr_data;
        rd_busy_next[p] = rsv_en && (rsv_addr == addr);
      end
`endif
    end
  end

  // Read output registers; a port without a strobe keeps its last result so
  // issue logic can keep looking at it while stalled.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data <= '0;
      rd_busy <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (rd_en[p]) begin
          rd_data[p*DATA_W +: DATA_W] <= rd_data_next[p];
          rd_busy[p]                  <= rd_busy_next[p];
        end
      end
    end
  end

endmodule
